// File: rtl/rns_pkg.sv
// rtl/rns_pkg.sv - shared RNS widths, moduli and residue triple type
package rns_pkg;
  localparam int N    = 5;
  localparam int W1   = N;
  localparam int W2   = N + 1;
  localparam int W3   = N;
  localparam int MOD2 = (1 << (N + 1)) - 1;
  localparam int MOD3 = (1 << N) - 1;
  localparam int M_DR = (1 << N) * MOD2 * MOD3;

  typedef struct packed {
    logic [W1-1:0] out1;
    logic [W2-1:0] out2;
    logic [W3-1:0] out3;
  } rns_triple_t;
endpackage

// File: rtl/mod_eac_add.sv
// rtl/mod_eac_add.sv - W-bit end-around-carry adder modulo 2^W-1, canonical output
module mod_eac_add #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic [W:0]   sum;
  logic [W-1:0] t;

  // Both operands are at most 2^W-1, so re-adding the carry cannot carry again.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    t   = sum[W-1:0] + {{(W-1){1'b0}}, sum[W]};
    y   = (&t) ? '0 : t;
  end
endmodule

// File: rtl/rns_fwd_conv.sv
// rtl/rns_fwd_conv.sv - 2-stage binary to RNS {2^N, 2^(N+1)-1, 2^N-1} forward converter
module rns_fwd_conv #(
  parameter int N  = rns_pkg::N,
  parameter int XW = 3 * N + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out1,
  output logic [N:0]    out2,
  output logic [N-1:0]  out3,
  output logic          out_ovf,
  output logic          out_last
);
  localparam int          XP3 = 4 * N;
  localparam int          XP2 = 3 * (N + 1);
  localparam logic [63:0] M   = (64'd1 << N) * ((64'd1 << (N + 1)) - 64'd1) * ((64'd1 << N) - 64'd1);

  logic en;

  logic [XP3-1:0] x3;
  logic [XP2-1:0] x2;
  logic [N-1:0]   a3, b3, c3, d3, s3a, m3a, c3a, s3n, m3n, c3n;
  logic [N:0]     a2, b2, c2, s2n, m2n, c2n;

  logic [N-1:0] r1_q, r1_d, s3_q, s3_d, cy3_q, cy3_d;
  logic [N:0]   s2_q, s2_d, cy2_q, cy2_d;
  logic         ovf1_q, ovf1_d, v1_q, v1_d, last1_q, last1_d;

  logic [N-1:0] out1_q, out1_d, out3_q, out3_d, sum3;
  logic [N:0]   out2_q, out2_d, sum2;
  logic         ovf_q, ovf_d, last_q, last_d, out_valid_q, out_valid_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Carry vectors rotate left by one: weight 2^W folds back to 1 modulo 2^W-1.
  always_comb begin
    x3  = XP3'(in_x);
    x2  = XP2'(in_x);
    a3  = x3[N-1:0];
    b3  = x3[2*N-1:N];
    c3  = x3[3*N-1:2*N];
    d3  = x3[4*N-1:3*N];
    s3a = a3 ^ b3 ^ c3;
    m3a = (a3 & b3) | (a3 & c3) | (b3 & c3);
    c3a = {m3a[N-2:0], m3a[N-1]};
    s3n = s3a ^ c3a ^ d3;
    m3n = (s3a & c3a) | (s3a & d3) | (c3a & d3);
    c3n = {m3n[N-2:0], m3n[N-1]};
    a2  = x2[N:0];
    b2  = x2[2*N+1:N+1];
    c2  = x2[3*N+2:2*N+2];
    s2n = a2 ^ b2 ^ c2;
    m2n = (a2 & b2) | (a2 & c2) | (b2 & c2);
    c2n = {m2n[N-1:0], m2n[N]};
  end

  mod_eac_add #(.W(N))     u_add3 (.a(s3_q), .b(cy3_q), .y(sum3));
  mod_eac_add #(.W(N + 1)) u_add2 (.a(s2_q), .b(cy2_q), .y(sum2));

  always_comb begin
    r1_d        = r1_q;
    s3_d        = s3_q;
    cy3_d       = cy3_q;
    s2_d        = s2_q;
    cy2_d       = cy2_q;
    ovf1_d      = ovf1_q;
    v1_d        = v1_q;
    last1_d     = last1_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    out3_d      = out3_q;
    ovf_d       = ovf_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    if (en) begin
      r1_d        = in_x[N-1:0];
      s3_d        = s3n;
      cy3_d       = c3n;
      s2_d        = s2n;
      cy2_d       = c2n;
      ovf1_d      = (64'(in_x) >= M);
      v1_d        = in_valid;
      last1_d     = in_last;
      out1_d      = r1_q;
      out2_d      = sum2;
      out3_d      = sum3;
      ovf_d       = ovf1_q;
      last_d      = last1_q;
      out_valid_d = v1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q        <= '0;
      s3_q        <= '0;
      cy3_q       <= '0;
      s2_q        <= '0;
      cy2_q       <= '0;
      ovf1_q      <= 1'b0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      out1_q      <= '0;
      out2_q      <= '0;
      out3_q      <= '0;
      ovf_q       <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      r1_q        <= r1_d;
      s3_q        <= s3_d;
      cy3_q       <= cy3_d;
      s2_q        <= s2_d;
      cy2_q       <= cy2_d;
      ovf1_q      <= ovf1_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      out3_q      <= out3_d;
      ovf_q       <= ovf_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out3      = out3_q;
  assign out_ovf   = ovf_q;
  assign out_last  = last_q;
endmodule

// File: tb/tb_rns_fwd_conv.sv
// tb/tb_rns_fwd_conv.sv - directed and stalled-stream checks for rns_fwd_conv
module tb_rns_fwd_conv;
  import rns_pkg::*;

  localparam int XW = 3 * N + 1;

  typedef struct {
    logic [XW-1:0] x;
    logic          last;
    rns_triple_t   r;
    logic          ovf;
  } vec_t;

  typedef struct {
    logic [XW-1:0] x;
    logic          last;
  } smp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] in_x = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  out1;
  logic [N:0]    out2;
  logic [N-1:0]  out3;
  logic          out_ovf;
  logic          out_last;

  int n_vec = 0;
  int n_err = 0;

  rns_fwd_conv #(.N(N), .XW(XW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .out2(out2), .out3(out3), .out_ovf(out_ovf), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] dut_tuple();
    return {out_valid, out1, out2, out3, out_ovf, out_last};
  endfunction

  function automatic logic [18:0] model(input logic [XW-1:0] x, input logic last);
    int xi;
    xi = int'(x);
    return {1'b1, 5'(xi % 32), 6'(xi % 63), 5'(xi % 31), (xi >= M_DR), last};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_check(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_x      = v.x;
    in_last   = v.last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 chk($sformatf("vec x=%0d", v.x), 32'(dut_tuple()),
           32'({1'b1, v.r.out1, v.r.out2, v.r.out3, v.ovf, v.last}));
  endtask

  vec_t tbl[7];
  smp_t exp_q[$];

  initial begin
    tbl[0] = '{x: 16'd0,     last: 1'b0, r: '{out1: 5'd0,  out2: 6'd0,  out3: 5'd0},  ovf: 1'b0};
    tbl[1] = '{x: 16'd31,    last: 1'b1, r: '{out1: 5'd31, out2: 6'd31, out3: 5'd0},  ovf: 1'b0};
    tbl[2] = '{x: 16'd63,    last: 1'b0, r: '{out1: 5'd31, out2: 6'd0,  out3: 5'd1},  ovf: 1'b0};
    tbl[3] = '{x: 16'd62495, last: 1'b0, r: '{out1: 5'd31, out2: 6'd62, out3: 5'd30}, ovf: 1'b0};
    tbl[4] = '{x: 16'd62496, last: 1'b1, r: '{out1: 5'd0,  out2: 6'd0,  out3: 5'd0},  ovf: 1'b1};
    tbl[5] = '{x: 16'd65535, last: 1'b0, r: '{out1: 5'd31, out2: 6'd15, out3: 5'd1},  ovf: 1'b1};
    tbl[6] = '{x: 16'd100,   last: 1'b0, r: '{out1: 5'd4,  out2: 6'd37, out3: 5'd7},  ovf: 1'b0};

    #12;
    chk("reset outputs", 32'(dut_tuple()), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) send_check(tbl[i]);

    // back-to-back stream 0..99
    repeat (3) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          in_valid = 1'b1;
          in_x     = XW'(i);
          in_last  = (i % 4 == 3);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 10) begin
          @(negedge clk);
          w++;
        end
        for (int k = 0; k < 100; k++) begin
          chk($sformatf("stream %0d", k), 32'(dut_tuple()), 32'(model(XW'(k), (k % 4 == 3))));
          @(negedge clk);
        end
      end
    join

    // reset with two samples in flight
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in_x     = 16'd7;
    @(negedge clk);
    in_x     = 16'd8;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("reset midstream out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post-reset out_valid", 32'(out_valid), 32'd0);
    end
    send_check(tbl[6]);

    // random valid with 30% out_ready and stall checks
    repeat (3) @(negedge clk);
    fork
      begin
        int   sent;
        int   cyc;
        logic acc;
        sent = 0;
        cyc  = 0;
        acc  = 1'b0;
        while (sent < 60 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          if (acc) in_valid = 1'b0;
          if (!in_valid && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b1;
            in_x     = XW'($urandom_range(0, 65535));
            in_last  = (sent % 4 == 3);
          end
          #4;
          acc = in_valid && in_ready;
          if (acc) begin
            exp_q.push_back('{x: in_x, last: in_last});
            sent++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        int          got;
        int          cyc;
        logic        stalled;
        logic [18:0] held;
        smp_t        s;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (got < 60 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          if (stalled) chk("stall hold", 32'(dut_tuple()), 32'(held));
          if (out_valid) begin
            if (exp_q.size() == 0) begin
              chk("unexpected output", 32'(out_valid), 32'd0);
            end else begin
              s = exp_q[0];
              chk($sformatf("random x=%0d", s.x), 32'(dut_tuple()), 32'(model(s.x, s.last)));
            end
          end
          out_ready = ($urandom_range(0, 9) < 3);
          #1 chk("in_ready mirror", 32'(in_ready), 32'(!out_valid || out_ready));
          stalled = out_valid && !out_ready;
          held    = dut_tuple();
          if (out_valid && out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            got++;
          end
        end
        chk("random outputs received", 32'(got), 32'd60);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rns_fwd_conv.md
# rns_fwd_conv

Pipelined binary-to-RNS forward converter for the moduli set {2^n, 2^(n+1)−1, 2^n−1}. It takes unsigned binary activations and emits canonical residue triples in the same order and widths that the RNS max-pooling comparator consumes. It sits at the entry of the RNS datapath, feeding the comparator and MAC stages. A valid/ready stream interface with full backpressure accepts one sample per cycle.

## Interface
- `N`, default 5: residue base width. The moduli are 2^N, 2^(N+1)−1 and 2^N−1.
- `XW`, default 3*N+1: input binary width.
- `clk`, input, 1 bit: the single clock; rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `in_valid`, input, 1 bit: input sample valid.
- `in_ready`, output, 1 bit: converter can accept a sample.
- `in_x`, input, XW bits: unsigned binary value.
- `in_last`, input, 1 bit: end-of-window marker, passed through with the sample.
- `out_valid`, output, 1 bit: residue triple valid.
- `out_ready`, input, 1 bit: downstream accepts.
- `out1`, output, N bits: X mod 2^N.
- `out2`, output, N+1 bits: X mod (2^(N+1)−1), canonical.
- `out3`, output, N bits: X mod (2^N−1), canonical.
- `out_ovf`, output, 1 bit: X ≥ M, where M = 2^N·(2^(N+1)−1)·(2^N−1).
- `out_last`, output, 1 bit: delayed `in_last`.

## Operation
- Transfer occurs on any edge where valid and ready are both high, on either side.
- Global advance: `en = !out_valid || out_ready`. `in_ready = en` (combinational). Both pipeline stages load only when `en` is high.
- Stage 1 (S1), registered:
  - `r1 = in_x[N-1:0]`.
  - mod 2^N−1: split `in_x` into N-bit chunks from the LSB; the top chunk is 1 bit, zero-extended. Reduce the four chunks with a carry-save tree to sum/carry vectors and register them.
  - mod 2^(N+1)−1: split into (N+1)-bit chunks; the top chunk is XW−2(N+1) bits, zero-extended. Reduce the three chunks with a carry-save stage, using end-around carry on the carry vector (bit rotation), and register.
  - `ovf = (in_x >= M)`. Register it together with `v1 = in_valid` and `last`.
- Stage 2 (S2), registered outputs:
  - Final modular additions use end-around carry: the carry-out is re-added at the LSB.
  - Canonicalisation: an all-ones result (2^N−1, or 2^(N+1)−1) maps to 0. The outputs never present a non-canonical residue.
  - `out_valid <= v1`, and `out1`, `out_ovf` and `out_last` follow from S1.
- Inputs ≥ M are converted normally, producing residues of X itself, with `out_ovf = 1`. There is no saturation.
- Bubbles: when `in_valid = 0` and `en = 1`, S1 loads `v1 = 0`. Data registers may load but are don't-care when invalid.

## Timing
- Latency is 2 cycles from input handshake to `out_valid`, with no stall. Throughput is 1 sample per cycle.
- Reset: `out_valid`, `v1`, `out1`, `out2`, `out3`, `out_ovf`, `out_last` and all S1 registers go to 0 asynchronously. `in_ready` is 1 during and after reset, since it is derived from `out_valid = 0`.
- Stall: while `out_valid && !out_ready`:
  - `out*` hold stable.
  - S1 holds.
  - `in_ready = 0`.
  - No sample is lost or duplicated.
- Simultaneous `out_ready` rise and `in_valid`: both transfers complete on the same edge and the pipeline shifts.
- Reset mid-stream: all in-flight samples are discarded. The first valid output after release is the first sample accepted after release.
- `in_x` and `in_last` are sampled only at handshake. A change while `in_ready = 0` has no effect.

## Structure
- Package `rns_pkg`:
  - `N`.
  - Widths `W1 = N`, `W2 = N+1`, `W3 = N`.
  - Moduli constants `MOD2 = 2^(N+1)−1`, `MOD3 = 2^N−1`.
  - `M_DR = 2^N·MOD2·MOD3`.
  - A `rns_triple_t` struct {out1, out2, out3}, shared with the comparator and MAC blocks.
- One sub-module, `mod_eac_add #(W)`: a W-bit end-around-carry adder with all-ones-to-zero canonicalisation. It is instantiated twice in S2, at W = N and W = N+1.
- Stage registers and handshake logic stay in the top module.

## Test plan
All cases use N = 5, M = 62496.
- `in_x = 0`, `out_ready = 1`: after 2 cycles, `out` = (0, 0, 0), ovf = 0.
- `in_x = 31` → (31, 31, 0): exercises mod-31 canonicalisation. `in_x = 63` → (31, 0, 1): exercises mod-63 canonicalisation.
- `in_x = 62495` → (31, 62, 30), ovf = 0. `in_x = 62496` → (0, 0, 0), ovf = 1. `in_x = 65535` → (31, 15, 1), ovf = 1.
- Back-to-back stream of 0..99 with `out_ready = 1`: 100 outputs on consecutive cycles, in order, matching the reference model.
- Random `out_ready` duty of 30% with `in_valid` random: outputs hold stable while stalled, `in_ready` mirrors the stall, in-order and lossless. `in_last` on every 4th sample emerges aligned.
- Assert `rst_n` low with 2 samples in flight: `out_valid` drops immediately and is 0 after release. The next accepted `in_x = 100` yields (4, 37, 7) after 2 cycles.
